// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants, state type and hex glyph table for the multiplexed
// seven-segment scan controller.
package seg_scan_ctrl_pkg;

    localparam int unsigned CODE_W = 5;
    localparam logic [CODE_W-1:0] BLANK_CODE = 5'd16;
    localparam int unsigned DIGITS = 8;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } scan_state_t;

    // Segment order is {g,f,e,d,c,b,a}; index is the hex value.
    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg_decode.sv
// Combinational digit-code to segment decoder; codes at or above the blank
// code produce an unlit digit.
module seg_decode
    import seg_scan_ctrl_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [6:0]        seg
);

    always_comb begin
        seg = '0;
        if (code < BLANK_CODE) begin
            seg = GLYPH[code[3:0]];
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner with a shadow/active
// double buffer, per-slot blanking and PWM-style brightness.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 100,
    parameter int unsigned BLANK_TICKS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [CODE_W-1:0] wr_code,
    input  logic              wr_dp,
    input  logic              commit,
    input  logic [2:0]        bright,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [7:0]        an,
    output logic              frame_start,
    output logic              commit_pending,
    output logic              commit_done
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [2:0] BT = 3'(BLANK_TICKS);

    logic [PW-1:0]     presc;
    logic [2:0]        slot;
    logic [2:0]        digit;
    logic [2:0]        bright_q;
    logic              fs_evt;
    scan_state_t       state_q, state_d;
    logic [CODE_W:0]   shadow [DIGITS];
    logic [CODE_W:0]   active [DIGITS];

    logic              tick;
    logic              frame_end;
    logic              copy;
    logic [CODE_W:0]   sel;
    logic [6:0]        glyph;
    logic [2:0]        k;
    logic              lit;

    assign tick      = (presc == PRESC_MAX);
    assign frame_end = tick && (slot == 3'd7) && (digit == 3'd7);
    assign copy      = frame_end && commit_pending;
    assign sel       = active[digit];
    assign k         = slot - BT;

    seg_decode u_decode (
        .code (sel[CODE_W-1:0]),
        .seg  (glyph)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lit     = 1'b0;
        if (tick) begin
            if (state_q == ST_SHOW && slot == 3'd7) begin
                state_d = ST_BLANK;
            end else if (state_q == ST_BLANK && (slot + 3'd1) == BT) begin
                state_d = ST_SHOW;
            end
        end
        // A blank code with its dp clear leaves the anode off entirely.
        if (state_q == ST_SHOW && k < bright_q &&
            (sel[CODE_W-1:0] < BLANK_CODE || sel[CODE_W])) begin
            lit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc          <= '0;
            slot           <= '0;
            digit          <= '0;
            bright_q       <= '0;
            fs_evt         <= 1'b1;
            commit_pending <= 1'b0;
            commit_done    <= 1'b0;
            seg            <= '0;
            dp             <= 1'b0;
            an             <= '0;
            frame_start    <= 1'b0;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                shadow[i] <= {1'b0, BLANK_CODE};
                active[i] <= {1'b0, BLANK_CODE};
            end
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                slot <= slot + 3'd1;
                if (slot == 3'd7) begin
                    digit <= digit + 3'd1;
                end
            end
            if (tick && state_q == ST_BLANK && state_d == ST_SHOW) begin
                bright_q <= bright;
            end

            // fs_evt starts high out of reset so the first slot is announced.
            fs_evt      <= frame_end;
            frame_start <= fs_evt;

            if (copy) begin
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    active[i] <= shadow[i];
                end
                commit_pending <= commit;
            end else if (commit) begin
                commit_pending <= 1'b1;
            end
            commit_done <= copy;

            if (wr_en) begin
                shadow[wr_addr] <= {wr_dp, wr_code};
            end

            an  <= lit ? (8'd1 << digit) : '0;
            seg <= lit ? glyph : '0;
            dp  <= lit && sel[CODE_W];
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 100, means system clocks per scan tick (legal range 2 or more).
REQ-002 Parameter BLANK_TICKS, default 1, means ticks of all-anodes-off at the start of each digit slot (legal range 1 to 7).
REQ-003 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 wr_en  input  1  write strobe into the shadow buffer.
REQ-006 wr_addr  input  3  shadow digit index.
REQ-007 wr_code  input  5  digit code: 0-15 is hex 0-F, 16-31 is blank.
REQ-008 wr_dp  input  1  decimal point for the addressed digit.
REQ-009 commit  input  1  pulse requesting a shadow-to-active copy.
REQ-010 bright  input  3  brightness, 0 is dark and 7 is full.
REQ-011 seg  output  7  segments a-g, active-high, seg[0]=a.
REQ-012 dp  output  1  decimal point, active-high.
REQ-013 an  output  8  one-hot digit enable, active-high, an[i] selects digit i.
REQ-014 frame_start  output  1  one-clock pulse when the digit-0 slot begins.
REQ-015 commit_pending  output  1  a commit has been accepted and not yet applied.
REQ-016 commit_done  output  1  one-clock pulse in the cycle after the copy.

Function
REQ-017 Prescaler: counts 0 to CLK_DIV-1 and wraps; a tick SHALL be asserted for one clk on the wrap.
REQ-018 Slot: each digit slot SHALL last 8 ticks, tracked by a 3-bit slot counter advanced on each tick.
REQ-019 FSM BLANK: slot counter < BLANK_TICKS; an=0, seg=0, dp=0.
REQ-020 FSM SHOW: remaining ticks of the slot; k = slot counter - BLANK_TICKS.
REQ-021 SHOW output: an[digit], seg and dp SHALL be driven only while k < bright, otherwise all zero.
REQ-022 Transition BLANK->SHOW SHALL occur on the tick where the slot counter reaches BLANK_TICKS.
REQ-023 Transition SHOW->BLANK SHALL occur on the tick where the slot counter wraps 7->0, and the digit index SHALL advance at the same tick.
REQ-024 Digit index SHALL advance 0->7 and wrap 7->0; the 7->0 wrap is the frame boundary.
REQ-025 frame_start SHALL pulse on the tick entering the digit-0 BLANK, including the first slot after reset.
REQ-026 bright SHALL be sampled once per slot, at BLANK->SHOW, and held for that slot.
REQ-027 Outputs SHALL be registered and reflect a state change one clk after the causing tick.
REQ-028 Decode: codes 0-15 SHALL map to standard hex glyphs (for example 8=7'h7F, 1=7'h06, A=7'h77); codes 16-31 SHALL map to 7'h00.
REQ-029 Writes: when wr_en is high, shadow[wr_addr] SHALL take {wr_dp, wr_code} at the next edge, at any time.
REQ-030 Commit: a commit pulse SHALL set commit_pending; a commit while already pending SHALL be absorbed, with no second copy.
REQ-031 Copy: at the frame boundary tick with commit_pending=1, active[0..7] SHALL take shadow[0..7] atomically, commit_pending SHALL clear, and commit_done SHALL pulse on the next clk.
REQ-032 A write in the copy cycle SHALL land in shadow only; active SHALL take the pre-write value.
REQ-033 A commit in the copy cycle SHALL leave commit_pending=1, to be applied at the next frame boundary.
REQ-034 The display SHALL read only the active buffer; a digit SHALL never change mid-frame.

Reset
REQ-035 While rst is high: prescaler=0, slot=0, digit=0, FSM=BLANK, shadow and active all code 16 with dp 0, all outputs 0.
REQ-036 Reset asserted mid-frame or mid-commit SHALL discard the pending commit and restart at digit-0 BLANK.

Structure
REQ-037 A shared package SHALL hold the code width (5), the blank code (16), the digit count (8), the FSM state enum, and the glyph constants.
REQ-038 One sub-module, seg_decode (5-bit code to 7 segments, combinational), SHALL be instantiated once on the selected active digit.

Verification (CLK_DIV=4, BLANK_TICKS=1)
REQ-039 Reset release, no writes, bright=7 -> an stays 0 throughout, frame_start every 256 clk.
REQ-040 Write digit 3 = code 8 with dp=1, commit, bright=7 -> after the next frame_start, an=8'h08 with seg=7'h7F and dp=1 for 7 ticks, after 1 blank tick, once per frame.
REQ-041 Same setup with bright=2 -> an=8'h08 for exactly 2 ticks (8 clk) per slot; bright=0 -> an never asserts.
REQ-042 Two commits mid-frame, then a write to digit 0 in the copy cycle -> exactly one commit_done; digit 0 is updated only after a further commit.
REQ-043 rst for 1 clk during the digit-5 SHOW with a commit pending -> outputs 0 the next clk, commit_pending=0, no commit_done, and the display is blank.
